// File: rtl/alu_drv_pkg.sv
// rtl/alu_drv_pkg.sv - shared types, ALU command codes and op mapping for alu_wide_driver
package alu_drv_pkg;

    // Wide operation requested by the datapath controller
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_XOR = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_e;

    // Command encodings understood by the 8-bit ALU
    localparam logic [2:0] ALU_CMD_ADD = 3'b000;
    localparam logic [2:0] ALU_CMD_XOR = 3'b011;
    localparam logic [2:0] ALU_CMD_AND = 3'b101;
    localparam logic [2:0] ALU_CMD_OR  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ADD_BEAT   = 3'd1,
        ST_FIX_BEAT   = 3'd2,
        ST_LOGIC_BEAT = 3'd3,
        ST_RESP       = 3'd4
    } state_e;

    function automatic logic [2:0] op_to_cmd(input op_e op);
        logic [2:0] cmd;
        case (op)
            OP_ADD:  cmd = ALU_CMD_ADD;
            OP_XOR:  cmd = ALU_CMD_XOR;
            OP_AND:  cmd = ALU_CMD_AND;
            default: cmd = ALU_CMD_OR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/alu_wide_driver.sv
// rtl/alu_wide_driver.sv - byte-serial initiator running one wide op through an 8-bit combinational ALU
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake; req_op, req_a, req_b latched on accept
//   rsp_valid/rsp_ready             response handshake; rsp_result/carry/zero/parity held while waiting
//   alu_cmd, alu_ina, alu_inb       per-byte command and operands to the ALU
//   alu_sc_i                        ALU carry-in, tied low (carries are chained here instead)
//   alu_rslt, alu_sc_o              same-cycle ALU result and carry-out
module alu_wide_driver
    import alu_drv_pkg::*;
#(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_carry,
    output logic         rsp_zero,
    output logic         rsp_parity,
    output logic [2:0]   alu_cmd,
    output logic [7:0]   alu_ina,
    output logic [7:0]   alu_inb,
    output logic         alu_sc_i,
    input  logic [7:0]   alu_rslt,
    input  logic         alu_sc_o
);

    localparam logic [1:0] IDX_LAST = 2'(NBYTES - 1);

    state_e       state_q, state_d;
    op_e          op_q;
    logic [W-1:0] a_q, b_q;
    logic [W-1:0] result_q, result_d;
    logic [1:0]   idx_q, idx_d;
    logic         c_q, c_d;
    logic         tmp_c_q, tmp_c_d;
    logic         accept;
    logic         rsp_load;

    logic [4:0]   bit_ofs;
    logic [W-1:0] a_sh, b_sh, res_sh;
    logic         last_byte;

    assign bit_ofs   = {idx_q, 3'b000};
    assign a_sh      = a_q >> bit_ofs;
    assign b_sh      = b_q >> bit_ofs;
    assign res_sh    = result_q >> bit_ofs;
    assign last_byte = (idx_q == IDX_LAST);

    assign alu_sc_i  = 1'b0;
    assign rsp_valid = (state_q == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        c_d       = c_q;
        tmp_c_d   = tmp_c_q;
        result_d  = result_q;
        alu_cmd   = ALU_CMD_ADD;
        alu_ina   = 8'h00;
        alu_inb   = 8'h00;
        req_ready = 1'b0;
        accept    = 1'b0;
        rsp_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept   = 1'b1;
                    idx_d    = 2'd0;
                    c_d      = 1'b0;
                    tmp_c_d  = 1'b0;
                    result_d = '0;
                    state_d  = (op_e'(req_op) == OP_ADD) ? ST_ADD_BEAT : ST_LOGIC_BEAT;
                end
            end

            ST_LOGIC_BEAT: begin
                alu_cmd = op_to_cmd(op_q);
                alu_ina = a_sh[7:0];
                alu_inb = b_sh[7:0];
                result_d[bit_ofs +: 8] = alu_rslt;
                if (last_byte) begin
                    state_d  = ST_RESP;
                    rsp_load = 1'b1;
                end else begin
                    idx_d = 2'(idx_q + 2'd1);
                end
            end

            ST_ADD_BEAT: begin
                alu_cmd = ALU_CMD_ADD;
                alu_ina = a_sh[7:0];
                alu_inb = b_sh[7:0];
                result_d[bit_ofs +: 8] = alu_rslt;
                tmp_c_d = alu_sc_o;
                if (idx_q == 2'd0) begin
                    // Byte 0 has no incoming carry, so no fix-up beat is needed.
                    c_d = alu_sc_o;
                    if (last_byte) begin
                        state_d  = ST_RESP;
                        rsp_load = 1'b1;
                    end else begin
                        idx_d = 2'(idx_q + 2'd1);
                    end
                end else begin
                    state_d = ST_FIX_BEAT;
                end
            end

            ST_FIX_BEAT: begin
                // Add the incoming carry to the partial byte; at most one of the
                // two additions for this byte can carry, so OR merges them.
                alu_cmd = ALU_CMD_ADD;
                alu_ina = res_sh[7:0];
                alu_inb = {7'b0, c_q};
                result_d[bit_ofs +: 8] = alu_rslt;
                c_d = tmp_c_q | alu_sc_o;
                if (last_byte) begin
                    state_d  = ST_RESP;
                    rsp_load = 1'b1;
                end else begin
                    idx_d   = 2'(idx_q + 2'd1);
                    state_d = ST_ADD_BEAT;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= 2'd0;
            c_q      <= 1'b0;
            tmp_c_q  <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q <= op_e'(req_op);
                a_q  <= req_a;
                b_q  <= req_b;
            end
            idx_q    <= idx_d;
            c_q      <= c_d;
            tmp_c_q  <= tmp_c_d;
            result_q <= result_d;
        end
    end

    // Response fields are captured once on entry to RESP and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_parity <= 1'b0;
        end else if (rsp_load) begin
            rsp_result <= result_d;
            rsp_carry  <= (op_q == OP_ADD) ? c_d : 1'b0;
            rsp_zero   <= (result_d == '0);
            rsp_parity <= ^result_d;
        end
    end

endmodule

// File: tb/tb_alu_wide_driver.sv
// tb/tb_alu_wide_driver.sv - randomized self-checking bench for alu_wide_driver with an 8-bit ALU model
module tb_alu_wide_driver;

    localparam int NBYTES = 2;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_zero, rsp_parity;
    logic [2:0]   alu_cmd;
    logic [7:0]   alu_ina, alu_inb;
    logic         alu_sc_i;
    logic [7:0]   alu_rslt;
    logic         alu_sc_o;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    alu_wide_driver #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_parity (rsp_parity),
        .alu_cmd    (alu_cmd),
        .alu_ina    (alu_ina),
        .alu_inb    (alu_inb),
        .alu_sc_i   (alu_sc_i),
        .alu_rslt   (alu_rslt),
        .alu_sc_o   (alu_sc_o)
    );

    // 8-bit combinational ALU: add ignores carry-in.
    always_comb begin
        alu_rslt = 8'h00;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            3'b000:  {alu_sc_o, alu_rslt} = {1'b0, alu_ina} + {1'b0, alu_inb};
            3'b011:  alu_rslt = alu_ina ^ alu_inb;
            3'b101:  alu_rslt = alu_ina & alu_inb;
            3'b110:  alu_rslt = alu_ina | alu_inb;
            default: alu_rslt = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: plain arithmetic on the full operands.
    task automatic ref_calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] r, output logic c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        case (op)
            2'd0: begin r = s[W-1:0]; c = s[W]; end
            2'd1: r = a ^ b;
            2'd2: r = a & b;
            default: r = a | b;
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_flags"}, {rsp_carry, rsp_zero, rsp_parity}, 0);
        check({tag, "_alu_cmd"}, alu_cmd, 0);
        check({tag, "_alu_ops"}, {alu_ina, alu_inb, alu_sc_i}, 0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit chk_lat, input bit poke);
        logic [W-1:0] er;
        logic         ec;
        int           lat;
        ref_calc(op, a, b, er, ec);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        lat = 0;
        while (!req_ready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("req_ready_at_request", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rsp_valid_rise", rsp_valid, 1);
        if (chk_lat) check("latency", lat, (op == 2'd0) ? 2 * NBYTES : NBYTES + 1);
        for (int k = 0; k < hold; k++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_op    = 2'($urandom);
                req_a     = W'($urandom);
                req_b     = W'($urandom);
            end
            @(posedge clk);
            #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, er);
            check("hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        check("result", rsp_result, er);
        check("carry", rsp_carry, ec);
        check("zero", rsp_zero, (er == '0));
        check("parity", rsp_parity, ^er);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("valid_drop", rsp_valid, 0);
        check("back_to_idle", req_ready, 1);
    endtask

    initial begin
        logic [W-1:0] er;
        logic         ec;
        int           lat;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("post_reset");

        // Directed cases
        run_op(2'd0, 16'h00FF, 16'h0001, 0, 1'b1, 1'b0);
        run_op(2'd0, 16'hFFFF, 16'h0001, 0, 1'b1, 1'b0);
        run_op(2'd1, 16'hA5A5, 16'h5A5A, 0, 1'b1, 1'b0);
        run_op(2'd2, 16'h1234, 16'h0F0F, 0, 1'b1, 1'b0);
        run_op(2'd3, 16'h1200, 16'h0034, 0, 1'b1, 1'b0);
        // Backpressure with ignored requests during the hold
        run_op(2'd0, 16'h1234, 16'h1111, 5, 1'b1, 1'b1);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 16'h8001;
        req_b     = 16'h8001;
        @(posedge clk);
        #1;
        check("b2b_first_accept", req_ready, 0);
        req_op = 2'd1;
        req_a  = 16'h3C3C;
        req_b  = 16'h0FF0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_first_result", rsp_result, 16'h0002);
        check("b2b_first_carry", rsp_carry, 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("b2b_idle_after_hs", req_ready, 1);
        check("b2b_valid_after_hs", rsp_valid, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_second_accept", req_ready, 0);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_second_latency", lat, NBYTES + 1);
        check("b2b_second_result", rsp_result, 16'h33CC);
        check("b2b_second_carry", rsp_carry, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset during the fix-up beat of 0xFFFF + 0x0001
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 16'hFFFF;
        req_b     = 16'h0001;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("fix_cmd", alu_cmd, 3'b000);
        check("fix_ina", alu_ina, 8'hFF);
        check("fix_inb", alu_inb, 8'h01);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                seen = seen | rsp_valid;
            end
            check("abort_no_rsp", seen, 0);
        end
        run_op(2'd0, 16'h0001, 16'h0001, 0, 1'b1, 1'b0);

        // Randomized operations with random backpressure
        for (int n = 0; n < 60; n++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom);
            a  = W'($urandom);
            b  = W'($urandom);
            case ($urandom_range(0, 5))
                0: a = '1;
                1: b = '0;
                2: b = ~a;
                default: ;
            endcase
            run_op(op, a, b, int'($urandom_range(0, 3)), 1'b1, 1'($urandom));
        end

        ref_calc(2'd0, 16'hFFFF, 16'hFFFF, er, ec);
        run_op(2'd0, 16'hFFFF, 16'hFFFF, 1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_wide_driver.md
Name: alu_wide_driver

Overview:
- Multi-cycle initiator for the 8-bit combinational ALU: accepts one wide (8*NBYTES-bit) operation over a valid/ready request channel.
- Drives the ALU's command/operand ports one byte per cycle, chaining carries in its own logic; the ALU's add ignores sc_i.
- Returns the wide result plus carry/zero/parity flags over a valid/ready response channel.
- Sits between the datapath controller and the ALU instance.

Parameters:
- NBYTES, 2, operand width in bytes; W = 8*NBYTES; legal range 1..4.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  driver idle, can accept
- req_op  input  2  0=ADD 1=XOR 2=AND 3=OR
- req_a  input  W  operand A
- req_b  input  W  operand B
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  W  wide result
- rsp_carry  output  1  carry out of MSB (ADD only, else 0)
- rsp_zero  output  1  rsp_result == 0
- rsp_parity  output  1  XOR-reduction of rsp_result
- alu_cmd  output  3  ALU command
- alu_ina  output  8  ALU operand A
- alu_inb  output  8  ALU operand B
- alu_sc_i  output  1  ALU carry-in, constant 0
- alu_rslt  input  8  ALU result, same cycle
- alu_sc_o  input  1  ALU carry-out, same cycle

Behaviour:
- Reset: state IDLE. req_ready=1. rsp_valid=0. rsp_result, rsp_carry, rsp_zero, rsp_parity = 0. alu_cmd=3'b000. alu_ina, alu_inb, alu_sc_i = 0. Byte index and carry registers = 0.
- Op to alu_cmd mapping: ADD->3'b000, XOR->3'b011, AND->3'b101, OR->3'b110.
- ALU is combinational: the driver presents operands in a cycle and captures alu_rslt/alu_sc_o on that cycle's closing edge.
- FSM states: IDLE, ADD_BEAT, FIX_BEAT, LOGIC_BEAT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, a, b; clear byte index i and carry c.
  - Go to ADD_BEAT if op is ADD, else LOGIC_BEAT.
- LOGIC_BEAT:
  - Drive the mapped cmd with a[8i+:8], b[8i+:8].
  - Capture alu_rslt into result byte i.
  - If i==NBYTES-1, go to RESP; else i++.
- ADD_BEAT:
  - Drive cmd 000 with byte i of a and b.
  - Capture alu_rslt into byte i; tmp_c = alu_sc_o.
  - If i==0: c = tmp_c; then i++ or go to RESP if NBYTES==1.
  - If i>0: go to FIX_BEAT.
- FIX_BEAT (byte i>0 only, always taken, constant latency):
  - Drive cmd 000 with ina = result byte i, inb = {7'b0, c}.
  - Capture alu_rslt into byte i; c = tmp_c | alu_sc_o.
  - Then i++ back to ADD_BEAT, or go to RESP if i==NBYTES-1.
- Latency, accept edge to rsp_valid high:
  - ADD: 2*NBYTES cycles (NBYTES=2: 4).
  - Logic ops: NBYTES+1 cycles (NBYTES=2: 3).
- RESP:
  - rsp_valid=1. Outputs are registered and hold stable while rsp_ready=0.
  - rsp_carry = c for ADD, 0 otherwise. zero/parity are computed from the final result.
  - On rsp_ready, go to IDLE; rsp_valid drops next cycle.
  - No new request is accepted in the same cycle as the handshake (req_ready=0 outside IDLE).
- Outside an active beat, alu_cmd and operands return to reset values.
- alu_rslt is captured verbatim for logic ops; the driver does no correction of ALU semantics.
- req fields are don't-care while req_ready=0. A latched request is unaffected by later changes on req_*.
- rst_n asserted mid-operation or mid-RESP: abort immediately to reset values; no response is ever issued for the aborted request.

Decomposition:
- Package alu_drv_pkg holds:
  - op_e enum (ADD, XOR, AND, OR)
  - ALU_CMD_ADD/XOR/AND/OR localparams
  - state_e enum
  - function op_to_cmd
- No sub-module inside the driver. The bench instantiates the existing ALU and connects it to the alu_* ports.

Test Plan:
- ADD 0x00FF+0x0001 -> 0x0100, carry 0, zero 0, parity 1; rsp_valid 4 cycles after accept.
- ADD 0xFFFF+0x0001 -> 0x0000, carry 1, zero 1, parity 0; FIX_BEAT observed driving alu_inb=0x01.
- XOR 0xA5A5^0x5A5A -> 0xFFFF, carry 0, parity 0, zero 0, latency 3. AND 0x1234&0x0F0F -> 0x0204, parity 0.
- Backpressure: ADD 0x1234+0x1111, rsp_ready low 5 cycles -> rsp_valid and 0x2345 held stable; req_ready=0 throughout; a new req_valid during the hold is ignored until return to IDLE.
- Back-to-back: two requests with req_valid held high -> second accepted the cycle after the first response handshake; both results correct.
- Reset during FIX_BEAT of 0xFFFF+0x0001 -> all outputs at reset values; after release no rsp_valid; next request 0x0001+0x0001 -> 0x0002.
